perf_monitor: RTL and testbench
===============================

// Module: perf_monitor
// PURPOSE
//  Performance and status monitor sitting between mips_core and the seven-segment decoders.
//  Counts run cycles, retired instructions and core memory requests while the core executes.
//  Latches pass/fail/done status from the core's MTC0 reports.
//  Drives a registered 8-nibble display word selected by the board switches.
// PARAMETERS
//  COUNT_WIDTH     32  width of every event counter
//  INC_WIDTH        8  width of per-cycle retired-instruction increment
//  PC_WIDTH        21  width of core IMEM word address
// PORTS
//  i_Clk                 in   1            core clock
//  i_Reset_n             in   1            async active-low reset
//  i_Loader_Done         in   1            flash loader finished; core is running
//  i_Pass_Done_Change    in   2            0 noop, 1 pass, 2 fail, 3 done
//  i_Pass_Done_Value     in   16           value attached to the MTC0 report
//  i_Num_Inst_Executed   in   INC_WIDTH    instructions retired this cycle
//  i_IMEM_Address        in   PC_WIDTH     current fetch address
//  i_MEM_Valid           in   1            core request to arbiter (level, held per transaction)
//  i_Sel                 in   2            display select (SW[1:0])
//  o_Cycle_Count         out  COUNT_WIDTH  run cycles
//  o_Inst_Count          out  COUNT_WIDTH  retired instructions
//  o_Mem_Req_Count       out  COUNT_WIDTH  core memory transactions started
//  o_Done                out  1            done latched
//  o_Fail                out  1            sticky: any fail report seen
//  o_Saturated           out  1            sticky: any counter saturated
//  o_Hex_Digits          out  32           nibble k = display digit k (digit 0 = bits 3:0)
// BEHAVIOUR
//  Reset (async, i_Reset_n=0): all outputs 0, all counters 0, FSM=LOAD. Takes effect mid-run too.
//  FSM states:
//   LOAD: wait for i_Loader_Done=1, then -> RUN. Status inputs ignored in LOAD.
//   RUN:  i_Pass_Done_Change==3 -> DONE, with o_Done=1 the next edge.
//   DONE: terminal until reset.
//  Counters update only in RUN, and not in the cycle where i_Pass_Done_Change==3:
//   cycle   +1
//   inst    +zero-extended i_Num_Inst_Executed
//   memreq  +1 on a 0->1 edge of i_MEM_Valid (previous-cycle sample registered; it is 0 after reset).
//  A high level held across cycles counts once. Back-to-back requests with a 1-cycle low gap count twice.
//  Saturation:
//   - A counter whose sum exceeds 2^COUNT_WIDTH-1 holds all-ones.
//   - o_Saturated is set the same edge.
//   - No wrap-around ever.
//  o_Fail:
//   - Set on any RUN cycle with i_Pass_Done_Change==2.
//   - Cleared only by reset.
//   - A fail and a done report in consecutive cycles set both o_Fail and o_Done.
//  Status latch: in RUN, a nonzero i_Pass_Done_Change captures {change,value} into pdf_reg.
//   The last report wins.
//  o_Hex_Digits is registered, 1-cycle latency from i_Sel and the counters (reflects pre-edge values):
//   i_Sel=0: d0-d1 = pdf_value[7:0]; d2 = {2'b0,pdf_change}; d6-d7 = i_IMEM_Address[7:0]; others 0
//   i_Sel=1: cycle[31:0]
//   i_Sel=2: inst[31:0]
//   i_Sel=3: memreq[31:0]
//  For COUNT_WIDTH<32 the counter is zero-extended; for >32 the low 32 bits are shown.
//  Counter outputs are the counter registers themselves, with no extra latency.
// TESTING
//  1. Reset, loader_done=0 for 10 cycles with inst=3 -> all counts 0, FSM stays LOAD.
//  2. loader_done=1, inst=2 for 100 cycles, then change=3 -> cycle=100, inst=200, o_Done=1.
//     Counts are frozen in the next 50 cycles.
//  3. MEM_Valid pattern 1,1,1,0,1,0,0,1 in RUN -> memreq=3.
//  4. Preload cycle to 0xFFFFFFFE, run 3 cycles -> cycle=0xFFFFFFFF, o_Saturated=1.
//  5. change=2 val=0x00AB, then change=3 val=0x0042, sel=0 -> o_Fail=1, o_Done=1.
//     Display: d1d0=42, d2=3.
//  6. Assert reset mid-RUN (cycle=57) -> all outputs 0 immediately.
//     Release with loader_done=1 -> counting restarts from 0.

Source files
------------

// File: rtl/perf_monitor.sv
// Performance/status monitor between mips_core and the seven-segment decoders: saturating
// run-time event counters, sticky MTC0 pass/fail/done status and a switch-selected display word.
module perf_monitor #(
  parameter int COUNT_WIDTH = 32,
  parameter int INC_WIDTH   = 8,
  parameter int PC_WIDTH    = 21
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Loader_Done,
  input  logic [1:0]             i_Pass_Done_Change,
  input  logic [15:0]            i_Pass_Done_Value,
  input  logic [INC_WIDTH-1:0]   i_Num_Inst_Executed,
  input  logic [PC_WIDTH-1:0]    i_IMEM_Address,
  input  logic                   i_MEM_Valid,
  input  logic [1:0]             i_Sel,
  output logic [COUNT_WIDTH-1:0] o_Cycle_Count,
  output logic [COUNT_WIDTH-1:0] o_Inst_Count,
  output logic [COUNT_WIDTH-1:0] o_Mem_Req_Count,
  output logic                   o_Done,
  output logic                   o_Fail,
  output logic                   o_Saturated,
  output logic [31:0]            o_Hex_Digits
);

  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic [1:0] PDC_FAIL = 2'd2;
  localparam logic [1:0] PDC_DONE = 2'd3;

  // Top bit of the result flags an overflow; the low bits then hold all-ones.
  function automatic logic [COUNT_WIDTH:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                   input logic [COUNT_WIDTH-1:0] b);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[COUNT_WIDTH]) sum = {1'b1, {COUNT_WIDTH{1'b1}}};
    return sum;
  endfunction

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d, inst_q, inst_d, memreq_q, memreq_d;
  logic [COUNT_WIDTH:0]   cycle_add, inst_add, memreq_add;
  logic                   done_q, done_d, fail_q, fail_d, sat_q, sat_d;
  logic                   mem_prev_q, mem_rise, count_en;
  logic [1:0]             pdf_change_q, pdf_change_d;
  logic [15:0]            pdf_value_q, pdf_value_d;
  logic [31:0]            hex_q, hex_d, cycle_disp, inst_disp, memreq_disp;
  logic                   unused_bits;

  assign mem_rise   = i_MEM_Valid & ~mem_prev_q;
  assign count_en   = (state_q == ST_RUN) && (i_Pass_Done_Change != PDC_DONE);
  assign cycle_add  = sat_add(cycle_q, COUNT_WIDTH'(1'b1));
  assign inst_add   = sat_add(inst_q, COUNT_WIDTH'(i_Num_Inst_Executed));
  assign memreq_add = sat_add(memreq_q, COUNT_WIDTH'(mem_rise));

  // Display always shows 32 bits of each counter regardless of its width.
  if (COUNT_WIDTH >= 32) begin : g_disp_trunc
    assign cycle_disp  = cycle_q[31:0];
    assign inst_disp   = inst_q[31:0];
    assign memreq_disp = memreq_q[31:0];
  end else begin : g_disp_ext
    assign cycle_disp  = {{(32-COUNT_WIDTH){1'b0}}, cycle_q};
    assign inst_disp   = {{(32-COUNT_WIDTH){1'b0}}, inst_q};
    assign memreq_disp = {{(32-COUNT_WIDTH){1'b0}}, memreq_q};
  end

  assign unused_bits = ^{i_IMEM_Address[PC_WIDTH-1:8], pdf_value_q[15:8]};

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    fail_d       = fail_q;
    sat_d        = sat_q;
    pdf_change_d = pdf_change_q;
    pdf_value_d  = pdf_value_q;
    cycle_d      = cycle_q;
    inst_d       = inst_q;
    memreq_d     = memreq_q;
    hex_d        = '0;

    case (state_q)
      ST_LOAD: if (i_Loader_Done) state_d = ST_RUN;
      ST_RUN: begin
        if (i_Pass_Done_Change != 2'd0) begin
          pdf_change_d = i_Pass_Done_Change;
          pdf_value_d  = i_Pass_Done_Value;
        end
        if (i_Pass_Done_Change == PDC_FAIL) fail_d = 1'b1;
        if (i_Pass_Done_Change == PDC_DONE) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase

    if (count_en) begin
      cycle_d  = cycle_add[COUNT_WIDTH-1:0];
      inst_d   = inst_add[COUNT_WIDTH-1:0];
      memreq_d = memreq_add[COUNT_WIDTH-1:0];
      sat_d    = sat_q | cycle_add[COUNT_WIDTH] | inst_add[COUNT_WIDTH] | memreq_add[COUNT_WIDTH];
    end

    case (i_Sel)
      2'd0:    hex_d = {i_IMEM_Address[7:0], 12'h000, 2'b00, pdf_change_q, pdf_value_q[7:0]};
      2'd1:    hex_d = cycle_disp;
      2'd2:    hex_d = inst_disp;
      default: hex_d = memreq_disp;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= ST_LOAD;
      cycle_q      <= '0;
      inst_q       <= '0;
      memreq_q     <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      sat_q        <= 1'b0;
      mem_prev_q   <= 1'b0;
      pdf_change_q <= '0;
      pdf_value_q  <= '0;
      hex_q        <= '0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      inst_q       <= inst_d;
      memreq_q     <= memreq_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      sat_q        <= sat_d;
      mem_prev_q   <= i_MEM_Valid;
      pdf_change_q <= pdf_change_d;
      pdf_value_q  <= pdf_value_d;
      hex_q        <= hex_d;
    end
  end

  assign o_Cycle_Count   = cycle_q;
  assign o_Inst_Count    = inst_q;
  assign o_Mem_Req_Count = memreq_q;
  assign o_Done          = done_q;
  assign o_Fail          = fail_q;
  assign o_Saturated     = sat_q;
  assign o_Hex_Digits    = hex_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit instance plus an 8-bit instance (to reach saturation quickly),
// both driven identically and compared against an unbounded-total reference model.
module tb_perf_monitor;
  localparam int CW  = 32;
  localparam int CWS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loader;
  logic [1:0]  chg;
  logic [15:0] val;
  logic [7:0]  inst;
  logic [20:0] addr;
  logic        memv;
  logic [1:0]  sel;

  logic [CW-1:0]  cyc_o, inst_o, mem_o;
  logic [CWS-1:0] cyc_s, inst_s, mem_s;
  logic           done_o, fail_o, sat_o, done_s, fail_s, sat_s;
  logic [31:0]    hex_o, hex_s;

  always #5 clk = ~clk;

  perf_monitor #(.COUNT_WIDTH(CW), .INC_WIDTH(8), .PC_WIDTH(21)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Loader_Done(loader), .i_Pass_Done_Change(chg),
    .i_Pass_Done_Value(val), .i_Num_Inst_Executed(inst), .i_IMEM_Address(addr),
    .i_MEM_Valid(memv), .i_Sel(sel), .o_Cycle_Count(cyc_o), .o_Inst_Count(inst_o),
    .o_Mem_Req_Count(mem_o), .o_Done(done_o), .o_Fail(fail_o), .o_Saturated(sat_o),
    .o_Hex_Digits(hex_o));

  perf_monitor #(.COUNT_WIDTH(CWS), .INC_WIDTH(8), .PC_WIDTH(21)) dut_s (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Loader_Done(loader), .i_Pass_Done_Change(chg),
    .i_Pass_Done_Value(val), .i_Num_Inst_Executed(inst), .i_IMEM_Address(addr),
    .i_MEM_Valid(memv), .i_Sel(sel), .o_Cycle_Count(cyc_s), .o_Inst_Count(inst_s),
    .o_Mem_Req_Count(mem_s), .o_Done(done_s), .o_Fail(fail_s), .o_Saturated(sat_s),
    .o_Hex_Digits(hex_s));

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: true event totals, clipped only when compared.
  bit          m_run, m_done, m_fail, m_prev;
  longint      m_cyc, m_inst, m_mem;
  logic [1:0]  m_pc;
  logic [15:0] m_pv;
  logic [31:0] m_hex32, m_hex8;

  function automatic longint cap(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit m_sat(int w);
    return (cap(m_cyc, w) != m_cyc) || (cap(m_inst, w) != m_inst) || (cap(m_mem, w) != m_mem);
  endfunction

  function automatic logic [31:0] disp(int w);
    logic [31:0] d;
    d = '0;
    case (sel)
      2'd0: begin
        d[7:0]   = m_pv[7:0];
        d[9:8]   = m_pc;
        d[31:24] = addr[7:0];
      end
      2'd1: d = 32'(cap(m_cyc, w));
      2'd2: d = 32'(cap(m_inst, w));
      default: d = 32'(cap(m_mem, w));
    endcase
    return d;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_fail = 0; m_prev = 0;
    m_cyc = 0; m_inst = 0; m_mem = 0;
    m_pc = '0; m_pv = '0; m_hex32 = '0; m_hex8 = '0;
  endfunction

  function automatic void model_edge();
    m_hex32 = disp(CW);
    m_hex8  = disp(CWS);
    if (m_run) begin
      if (chg != 2'd0) begin
        m_pc = chg;
        m_pv = val;
      end
      if (chg == 2'd2) m_fail = 1;
      if (chg == 2'd3) begin
        m_run  = 0;
        m_done = 1;
      end else begin
        m_cyc  = m_cyc + 1;
        m_inst = m_inst + longint'(inst);
        if (memv && !m_prev) m_mem = m_mem + 1;
      end
    end else if (!m_done && loader) begin
      m_run = 1;
    end
    m_prev = memv;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cyc"},    cyc_o,  cap(m_cyc, CW));
    chk({tag, ".inst"},   inst_o, cap(m_inst, CW));
    chk({tag, ".mem"},    mem_o,  cap(m_mem, CW));
    chk({tag, ".done"},   done_o, m_done);
    chk({tag, ".fail"},   fail_o, m_fail);
    chk({tag, ".sat"},    sat_o,  m_sat(CW));
    chk({tag, ".hex"},    hex_o,  m_hex32);
    chk({tag, ".s_cyc"},  cyc_s,  cap(m_cyc, CWS));
    chk({tag, ".s_inst"}, inst_s, cap(m_inst, CWS));
    chk({tag, ".s_mem"},  mem_s,  cap(m_mem, CWS));
    chk({tag, ".s_done"}, done_s, m_done);
    chk({tag, ".s_fail"}, fail_s, m_fail);
    chk({tag, ".s_sat"},  sat_s,  m_sat(CWS));
    chk({tag, ".s_hex"},  hex_s,  m_hex8);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        v;
    logic [7:0]  inc;
    logic [7:0]  exp_mem;
    logic [15:0] exp_inst;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl = '{'{1'b1, 8'd1, 8'd1, 16'd1}, '{1'b1, 8'd0, 8'd1, 16'd1},
            '{1'b1, 8'd2, 8'd1, 16'd3}, '{1'b0, 8'd0, 8'd1, 16'd3},
            '{1'b1, 8'd5, 8'd2, 16'd8}, '{1'b0, 8'd0, 8'd2, 16'd8},
            '{1'b0, 8'd1, 8'd2, 16'd9}, '{1'b1, 8'd0, 8'd3, 16'd9}};
    rst_n = 1'b0; loader = 1'b0; chg = 2'd0; val = '0; inst = '0;
    addr = '0; memv = 1'b0; sel = 2'd1;

    // Loader not done: nothing counts.
    apply_reset();
    inst = 8'd3;
    for (int i = 0; i < 10; i++) step("load");
    chk("load_cyc_zero", cyc_o, 64'd0);
    chk("load_inst_zero", inst_o, 64'd0);

    // Run 100 cycles at 2 inst/cycle, then done; counters freeze afterwards.
    loader = 1'b1; inst = 8'd2;
    step("start");
    for (int i = 0; i < 100; i++) step("run100");
    chg = 2'd3;
    step("done");
    chk("run_cyc_100", cyc_o, 64'd100);
    chk("run_inst_200", inst_o, 64'd200);
    chk("run_done", done_o, 64'd1);
    chg = 2'd0;
    for (int i = 0; i < 50; i++) begin
      memv = i[0];
      step("frozen");
    end
    chk("frozen_cyc", cyc_o, 64'd100);
    chk("frozen_inst", inst_o, 64'd200);
    chk("frozen_mem", mem_o, 64'd0);
    sel = 2'd1;
    step("disp_cyc");
    chk("disp_cyc_100", hex_o, 64'h64);

    // Memory-request edge counting from a table.
    apply_reset();
    memv = 1'b0; inst = 8'd0;
    step("start3");
    for (int i = 0; i < 8; i++) begin
      memv = tbl[i].v;
      inst = tbl[i].inc;
      step("tbl");
      chk("tbl_mem", mem_o, 64'(tbl[i].exp_mem));
      chk("tbl_inst", inst_o, 64'(tbl[i].exp_inst));
      chk("tbl_cyc", cyc_o, 64'(i + 1));
    end
    chk("mem_pattern_3", mem_o, 64'd3);

    // Saturate the narrow cycle counter exactly at the all-ones boundary.
    memv = 1'b0; inst = 8'd0; sel = 2'd1;
    for (int i = 0; i < 247; i++) step("to_sat");
    chk("sat_edge_cyc", cyc_s, 64'hFF);
    chk("sat_edge_flag_clear", sat_s, 64'd0);
    step("sat_over");
    chk("sat_cyc_hold", cyc_s, 64'hFF);
    chk("sat_flag_set", sat_s, 64'd1);
    chk("sat_disp", hex_s, 64'hFF);
    for (int i = 0; i < 5; i++) step("sat_hold");
    chk("sat_no_wrap", cyc_s, 64'hFF);
    chk("wide_not_sat", sat_o, 64'd0);

    // Fail then done reports, shown on the status display.
    apply_reset();
    loader = 1'b1;
    step("start5");
    for (int i = 0; i < 3; i++) step("pre5");
    chg = 2'd2; val = 16'h00AB;
    step("fail_rep");
    chg = 2'd3; val = 16'h0042;
    step("done_rep");
    chg = 2'd0; val = 16'h0000; sel = 2'd0; addr = 21'h0ABCD;
    step("disp_status");
    chk("fail_set", fail_o, 64'd1);
    chk("done_set", done_o, 64'd1);
    chk("disp_d1d0", hex_o[7:0], 64'h42);
    chk("disp_d2", hex_o[11:8], 64'h3);
    chk("disp_d7d6", hex_o[31:24], 64'hCD);

    // Asynchronous reset mid-run, then a fresh count.
    apply_reset();
    loader = 1'b1;
    step("start6");
    for (int i = 0; i < 57; i++) begin
      inst = 8'($urandom_range(0, 4));
      memv = 1'($urandom_range(0, 1));
      step("pre6");
    end
    chk("mid_cyc_57", cyc_o, 64'd57);
    rst_n = 1'b0;
    #1;
    chk("async_cyc", cyc_o, 64'd0);
    chk("async_inst", inst_o, 64'd0);
    chk("async_mem", mem_o, 64'd0);
    chk("async_hex", hex_o, 64'd0);
    chk("async_flags", {done_o, fail_o, sat_o}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    memv = 1'b0;
    step("restart");
    for (int i = 0; i < 5; i++) step("recount");
    chk("recount_cyc_5", cyc_o, 64'd5);

    // Randomized epochs against the model.
    for (int e = 0; e < 4; e++) begin
      apply_reset();
      loader = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) step("rnd_load");
      for (int k = 0; k < 300; k++) begin
        int r;
        r = int'($urandom_range(0, 199));
        chg    = (r == 0) ? 2'd3 : (r < 6) ? 2'd2 : (r < 12) ? 2'd1 : 2'd0;
        val    = 16'($urandom);
        loader = ($urandom_range(0, 7) != 0);
        inst   = 8'($urandom_range(0, 255));
        memv   = 1'($urandom_range(0, 1));
        sel    = 2'($urandom_range(0, 3));
        addr   = 21'($urandom);
        step("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
